// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC register, memory fetch FSM, JAL static prediction, redirects and stalls.
// Optional direct-mapped instruction cache is compiled in with `define INST_FETCH_ICACHE_EN.
module inst_fetch #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned ICACHE_IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        jump_enable_i,
   input  logic [31:0] jump_pc_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_inst_i,
   output logic        inst_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic [31:0] predicted_pc_o
);

   // Memory handshake: mem_req_o/mem_addr_o stay asserted and unchanged until the
   // controller answers with a one-cycle mem_ready_i pulse carrying mem_inst_i.
   // Downstream handshake: the presented word is consumed when inst_valid_o && !stall_i.

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_addr_q, drop_addr_d;
   logic        first_q, first_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pred_q, pred_d;

   logic        req;
   logic [31:0] req_addr;
   logic        hit;
   logic [31:0] hit_inst;
   logic        accept;
   logic [31:0] load_inst;

   if (ICACHE_IDX_W < 1 || ICACHE_IDX_W > 29) begin : g_idx_chk
      $error("inst_fetch: ICACHE_IDX_W out of range");
   end

   function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] i);
      logic [31:0] nxt;
      if (i[6:0] == 7'b1101111) begin
         nxt = pc + {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      end else begin
         nxt = pc + 32'd4;
      end
      return nxt;
   endfunction

   // DROP keeps the abandoned address on the bus; the controller cannot abort.
   always_comb begin
      req      = 1'b0;
      req_addr = '0;
      case (state_q)
         FETCH: begin
            if (!first_q && !hit) begin
               req      = 1'b1;
               req_addr = pc_q;
            end
         end
         DROP: begin
            req      = 1'b1;
            req_addr = drop_addr_q;
         end
         default: ;
      endcase
   end

`ifdef INST_FETCH_ICACHE_EN
   localparam int unsigned LINES = 1 << ICACHE_IDX_W;
   localparam int unsigned TAG_W = 30 - ICACHE_IDX_W;

   logic [31:0]             line_data_q [LINES];
   logic [TAG_W-1:0]        line_tag_q  [LINES];
   logic [LINES-1:0]        line_vld_q, line_vld_d;
   logic [ICACHE_IDX_W-1:0] rd_idx, wr_idx;
   logic                    fill;

   assign rd_idx   = pc_q[ICACHE_IDX_W+1:2];
   assign wr_idx   = req_addr[ICACHE_IDX_W+1:2];
   assign fill     = req && mem_ready_i;
   assign hit      = (state_q == FETCH) && !first_q && line_vld_q[rd_idx] &&
                     (line_tag_q[rd_idx] == pc_q[31:ICACHE_IDX_W+2]);
   assign hit_inst = line_data_q[rd_idx];

   // Every returned word fills its line, including words discarded in DROP.
   always_comb begin
      line_vld_d = line_vld_q;
      if (fill) begin
         line_vld_d[wr_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_vld_q <= '0;
      end else begin
         line_vld_q <= line_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         line_data_q[wr_idx] <= mem_inst_i;
         line_tag_q[wr_idx]  <= req_addr[31:ICACHE_IDX_W+2];
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_inst = '0;
`endif

   assign accept    = valid_q && !stall_i;
   assign load_inst = hit ? hit_inst : mem_inst_i;
   assign first_d   = 1'b0;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_addr_d = drop_addr_q;
      valid_d     = valid_q;
      pc_out_d    = pc_out_q;
      inst_d      = inst_q;
      pred_d      = pred_q;
      if (jump_enable_i) begin
         // Redirect beats stall and acceptance; an unanswered request must still be drained.
         pc_d    = jump_pc_i;
         valid_d = 1'b0;
         if (req && !mem_ready_i) begin
            state_d     = DROP;
            drop_addr_d = req_addr;
         end else begin
            state_d = FETCH;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (hit || (req && mem_ready_i)) begin
                  valid_d  = 1'b1;
                  inst_d   = load_inst;
                  pc_out_d = pc_q;
                  pred_d   = predict(pc_q, load_inst);
                  state_d  = HOLD;
               end
            end
            HOLD: begin
               if (accept) begin
                  pc_d    = pred_q;
                  valid_d = 1'b0;
                  state_d = FETCH;
               end
            end
            DROP: begin
               if (mem_ready_i) begin
                  state_d = FETCH;
               end
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         drop_addr_q <= '0;
         first_q     <= 1'b1;
         valid_q     <= 1'b0;
         pc_out_q    <= '0;
         inst_q      <= '0;
         pred_q      <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_addr_q <= drop_addr_d;
         first_q     <= first_d;
         valid_q     <= valid_d;
         pc_out_q    <= pc_out_d;
         inst_q      <= inst_d;
         pred_q      <= pred_d;
      end
   end

   assign mem_req_o      = req;
   assign mem_addr_o     = req_addr;
   assign inst_valid_o   = valid_q;
   assign pc_o           = pc_out_q;
   assign inst_o         = inst_q;
   assign predicted_pc_o = pred_q;

endmodule
